// File: rtl/spi_shift_engine.sv
// spi_shift_engine: byte-serial SPI master shift engine.
// Pops bytes from the TX FIFO side, shifts them out MSB first on SPI_MOSI,
// shifts SPI_MISO into a receive register and pushes each byte to the RX
// FIFO side. CS stays low across back-to-back bytes so a multi-byte command
// forms one frame.
//
// Handshake: TX side is strict valid/ready. A byte transfers on the rising
// ACLK edge where TX_VALID & TX_READY are both high. TX_VALID may not depend
// on TX_READY. TX_READY is only offered in IDLE and on the last cycle of
// HOLD, and is forced low while RST is high. RX_VALID is a one-cycle push
// strobe with no back-pressure; RX_DATA holds the last received byte.
module spi_shift_engine #(
  parameter int CS_IDLE_HP = 1
) (
  input  logic       ACLK,
  input  logic       RST,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic [1:0] DIV,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       BUSY,
  output logic       SPI_SCK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_CS
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_DEASSERT = 3'd4
  } state_t;

  state_t     state_q,    state_d;
  logic [2:0] hp_cnt_q,   hp_cnt_d;    // ACLK cycles left in this half-period
  logic [3:0] edge_cnt_q, edge_cnt_d;  // SCK edges done in SHIFT / half-periods in DEASSERT
  logic       cpol_q,     cpol_d;
  logic       cpha_q,     cpha_d;
  logic [1:0] div_q,      div_d;
  logic [7:0] tx_sr_q,    tx_sr_d;     // bit 7 drives MOSI
  logic [7:0] rx_sr_q,    rx_sr_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       cs_q,       cs_d;
  logic       sck_q,      sck_d;

  logic       hp_done;
  logic       tx_accept;
  logic       odd_edge;
  logic       sample_edge;
  logic       shift_edge;
  logic [7:0] rx_shift_in;

  // Half-period reload value: 2^div - 1 ACLK cycles after the current one.
  function automatic logic [2:0] hp_reload(input logic [1:0] div);
    logic [2:0] r;
    case (div)
      2'd0:    r = 3'd0;
      2'd1:    r = 3'd1;
      2'd2:    r = 3'd3;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  assign hp_done   = (hp_cnt_q == 3'd0);
  assign TX_READY  = ~RST & TX_VALID &
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && hp_done));
  assign tx_accept = TX_VALID & TX_READY;

  // The edge about to happen is number edge_cnt_q+1; odd edges are leading edges.
  assign odd_edge    = ~edge_cnt_q[0];
  assign sample_edge = cpha_q ? ~odd_edge : odd_edge;
  // CPHA=0 moves MOSI on trailing edges 2..14; CPHA=1 on leading edges 3..15
  // (edge 1 keeps bit 7, which was already placed in SETUP/HOLD).
  assign shift_edge  = cpha_q ? (odd_edge  && (edge_cnt_q != 4'd0))
                              : (~odd_edge && (edge_cnt_q != 4'd15));
  assign rx_shift_in = {rx_sr_q[6:0], SPI_MISO};

  // Next-state and datapath decode for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    hp_cnt_d   = hp_done ? hp_reload(div_q) : (hp_cnt_q - 3'd1);
    edge_cnt_d = edge_cnt_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cs_d       = cs_q;
    sck_d      = sck_q;

    case (state_q)
      ST_IDLE: begin
        cs_d     = 1'b1;
        sck_d    = CPOL;
        hp_cnt_d = hp_reload(DIV);
        if (tx_accept) begin
          state_d    = ST_SETUP;
          cpol_d     = CPOL;
          cpha_d     = CPHA;
          div_d      = DIV;
          tx_sr_d    = TX_DATA;
          cs_d       = 1'b0;
          edge_cnt_d = 4'd0;
        end
      end

      ST_SETUP: begin
        cs_d  = 1'b0;
        sck_d = cpol_q;
        if (hp_done) begin
          state_d    = ST_SHIFT;
          edge_cnt_d = 4'd0;
        end
      end

      ST_SHIFT: begin
        if (hp_done) begin
          sck_d      = ~sck_q;
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (sample_edge) rx_sr_d = rx_shift_in;
          if (shift_edge)  tx_sr_d = {tx_sr_q[6:0], 1'b0};
          if (edge_cnt_q == 4'd15) begin
            state_d    = ST_HOLD;
            sck_d      = cpol_q;
            edge_cnt_d = 4'd0;
            rx_data_d  = sample_edge ? rx_shift_in : rx_sr_q;
            rx_valid_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (hp_done) begin
          edge_cnt_d = 4'd0;
          if (tx_accept) begin
            state_d = ST_SHIFT;
            tx_sr_d = TX_DATA;
          end else begin
            state_d = ST_DEASSERT;
            cs_d    = 1'b1;
            sck_d   = cpol_q;
          end
        end
      end

      ST_DEASSERT: begin
        cs_d  = 1'b1;
        sck_d = cpol_q;
        if (hp_done) begin
          if (edge_cnt_q == 4'(CS_IDLE_HP - 1)) begin
            state_d    = ST_IDLE;
            edge_cnt_d = 4'd0;
          end else begin
            edge_cnt_d = edge_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any frame on the next edge.
  always_ff @(posedge ACLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      hp_cnt_q   <= 3'd0;
      edge_cnt_q <= 4'd0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= 2'd0;
      tx_sr_q    <= 8'd0;
      rx_sr_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
    end
  end

  assign BUSY     = (state_q != ST_IDLE);
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign SPI_CS   = cs_q;
  assign SPI_SCK  = sck_q;
  assign SPI_MOSI = tx_sr_q[7];

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with MOSI looped back to MISO.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [1:0] div = 2'd0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_buf [4];
  logic [7:0] exp_q [$];
  logic [7:0] rx_log [$];

  // Free-running monitor totals; tests work on deltas.
  int cyc = 0, rise_tot = 0, rise_period = 0, last_rise = 0;
  int csrise_tot = 0, cslow_tot = 0, busy_tot = 0, acc_tot = 0;
  logic [7:0] mosi_cap = 8'd0;
  logic prev_sck = 1'b0, prev_cs = 1'b1;

  int s_rise, s_csr, s_cs, s_busy, s_acc, s_rx;

  assign spi_miso = spi_mosi;

  spi_shift_engine #(.CS_IDLE_HP(1)) dut (
    .ACLK(clk), .RST(rst), .CPOL(cpol), .CPHA(cpha), .DIV(div),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .BUSY(busy),
    .SPI_SCK(spi_sck), .SPI_MOSI(spi_mosi), .SPI_MISO(spi_miso), .SPI_CS(spi_cs)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (spi_sck && !prev_sck) begin
      rise_tot++;
      rise_period = cyc - last_rise;
      last_rise = cyc;
      mosi_cap = {mosi_cap[6:0], spi_mosi};
    end
    if (spi_cs && !prev_cs) csrise_tot++;
    if (!spi_cs) cslow_tot++;
    if (busy) busy_tot++;
    if (tx_valid && tx_ready) acc_tot++;
    if (rx_valid) rx_log.push_back(rx_data);
    prev_sck = spi_sck;
    prev_cs = spi_cs;
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_rise = rise_tot; s_csr = csrise_tot; s_cs = cslow_tot;
    s_busy = busy_tot; s_acc = acc_tot; s_rx = rx_log.size();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    step();
  endtask

  // Present one byte and drop TX_VALID right after it is accepted.
  task automatic start_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    step();
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Hold TX_VALID and stream tx_buf[0..n-1], then wait for the frame to end.
  task automatic send_bytes(input int n, output bit ok);
    int idx;
    bit acc;
    bit ok2;
    idx = 0;
    ok = 1'b1;
    step();
    tx_data = tx_buf[0];
    tx_valid = 1'b1;
    for (int g = 0; g < 3000 && idx < n; g++) begin
      @(negedge clk);
      acc = tx_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < n) tx_data = tx_buf[idx];
        else tx_valid = 1'b0;
      end
    end
    if (idx < n) ok = 1'b0;
    tx_valid = 1'b0;
    wait_idle(5000, ok2);
    ok = ok & ok2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpol = 1'b1;
    tx_valid = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (spi_cs !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", spi_cs); end
    checks++; if (spi_sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", spi_sck); end
    checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    cpol = 1'b0;
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic test_single_byte();
    bit ok;
    cpol = 1'b0; cpha = 1'b0; div = 2'd3;
    step();
    step();
    snap();
    tx_data = 8'h06;
    tx_valid = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL t1_ready got=%b exp=1", tx_ready); end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    @(negedge clk);
    checks++; if (spi_cs !== 1'b0) begin failures++; $display("FAIL t1_cs_low got=%b exp=0", spi_cs); end
    wait_idle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t1_timeout got=busy exp=idle"); end
    checks++; if (acc_tot - s_acc != 1) begin failures++; $display("FAIL t1_accepts got=%0d exp=1", acc_tot - s_acc); end
    checks++; if (cslow_tot - s_cs != 144) begin failures++; $display("FAIL t1_cs_low_cycles got=%0d exp=144", cslow_tot - s_cs); end
    checks++; if (busy_tot - s_busy != 152) begin failures++; $display("FAIL t1_busy_cycles got=%0d exp=152", busy_tot - s_busy); end
    checks++; if (rise_tot - s_rise != 8) begin failures++; $display("FAIL t1_sck_pulses got=%0d exp=8", rise_tot - s_rise); end
    checks++; if (rise_period != 16) begin failures++; $display("FAIL t1_sck_period got=%0d exp=16", rise_period); end
    checks++; if (mosi_cap !== 8'h06) begin failures++; $display("FAIL t1_mosi_bits got=%h exp=06", mosi_cap); end
    checks++; if (rx_log.size() - s_rx != 1) begin failures++; $display("FAIL t1_rx_count got=%0d exp=1", rx_log.size() - s_rx); end
    else begin
      checks++; if (rx_log[s_rx] !== 8'h06) begin failures++; $display("FAIL t1_rx_data got=%h exp=06", rx_log[s_rx]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] e;
    cpol = 1'b0; cpha = 1'b0; div = 2'd0;
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'hF0; tx_buf[3] = 8'hAA;
    for (int i = 0; i < 4; i++) exp_q.push_back(tx_buf[i]);
    step();
    snap();
    send_bytes(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t2_timeout got=stalled exp=done"); end
    checks++; if (acc_tot - s_acc != 4) begin failures++; $display("FAIL t2_accepts got=%0d exp=4", acc_tot - s_acc); end
    checks++; if (rise_tot - s_rise != 32) begin failures++; $display("FAIL t2_sck_pulses got=%0d exp=32", rise_tot - s_rise); end
    checks++; if (csrise_tot - s_csr != 1) begin failures++; $display("FAIL t2_cs_rises got=%0d exp=1", csrise_tot - s_csr); end
    checks++; if (cslow_tot - s_cs != 69) begin failures++; $display("FAIL t2_cs_low_cycles got=%0d exp=69", cslow_tot - s_cs); end
    checks++; if (rx_log.size() - s_rx != 4) begin failures++; $display("FAIL t2_rx_count got=%0d exp=4", rx_log.size() - s_rx); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      if (s_rx + i < rx_log.size()) begin
        checks++; if (rx_log[s_rx + i] !== e) begin failures++; $display("FAIL t2_rx_byte%0d got=%h exp=%h", i, rx_log[s_rx + i], e); end
      end
    end
  endtask

  task automatic test_modes();
    bit ok;
    for (int m = 0; m < 4; m++) begin
      cpol = m[1]; cpha = m[0]; div = 2'd0;
      tx_buf[0] = 8'hA5;
      step();
      step();
      checks++; if (spi_sck !== cpol) begin failures++; $display("FAIL t3_idle_before_m%0d got=%b exp=%b", m, spi_sck, cpol); end
      snap();
      send_bytes(1, ok);
      checks++; if (spi_sck !== cpol) begin failures++; $display("FAIL t3_idle_after_m%0d got=%b exp=%b", m, spi_sck, cpol); end
      checks++; if (rise_tot - s_rise != 8) begin failures++; $display("FAIL t3_sck_pulses_m%0d got=%0d exp=8", m, rise_tot - s_rise); end
      checks++; if (!ok || rx_log.size() - s_rx != 1) begin failures++; $display("FAIL t3_rx_count_m%0d got=%0d exp=1", m, rx_log.size() - s_rx); end
      else begin
        checks++; if (rx_log[s_rx] !== 8'hA5) begin failures++; $display("FAIL t3_rx_m%0d got=%h exp=a5", m, rx_log[s_rx]); end
      end
    end
  endtask

  task automatic test_cfg_change();
    bit ok;
    cpol = 1'b0; cpha = 1'b0; div = 2'd0;
    step();
    step();
    snap();
    start_byte(8'h3C, ok);
    repeat (5) step();
    cpol = 1'b1;
    div = 2'd1;
    wait_idle(200, ok);
    checks++; if (busy_tot - s_busy != 19) begin failures++; $display("FAIL t4_busy_old got=%0d exp=19", busy_tot - s_busy); end
    checks++; if (cslow_tot - s_cs != 18) begin failures++; $display("FAIL t4_cs_low_old got=%0d exp=18", cslow_tot - s_cs); end
    checks++; if (rise_tot - s_rise != 8) begin failures++; $display("FAIL t4_sck_pulses_old got=%0d exp=8", rise_tot - s_rise); end
    checks++; if (rx_log.size() - s_rx != 1 || rx_log[rx_log.size() - 1] !== 8'h3C) begin failures++; $display("FAIL t4_rx_old got=%h exp=3c", rx_log[rx_log.size() - 1]); end
    step();
    step();
    checks++; if (spi_sck !== 1'b1) begin failures++; $display("FAIL t4_idle_new got=%b exp=1", spi_sck); end
    snap();
    tx_buf[0] = 8'h81;
    send_bytes(1, ok);
    checks++; if (busy_tot - s_busy != 38) begin failures++; $display("FAIL t4_busy_new got=%0d exp=38", busy_tot - s_busy); end
    checks++; if (rise_period != 4) begin failures++; $display("FAIL t4_sck_period_new got=%0d exp=4", rise_period); end
    checks++; if (rx_log.size() - s_rx != 1 || rx_log[rx_log.size() - 1] !== 8'h81) begin failures++; $display("FAIL t4_rx_new got=%h exp=81", rx_log[rx_log.size() - 1]); end
    checks++; if (spi_sck !== 1'b1) begin failures++; $display("FAIL t4_idle_after got=%b exp=1", spi_sck); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n;
    logic p;
    cpol = 1'b1; cpha = 1'b0; div = 2'd0;
    step();
    step();
    snap();
    start_byte(8'hFF, ok);
    p = spi_sck;
    n = 0;
    for (int i = 0; i < 100 && n < 7; i++) begin
      @(negedge clk);
      if (spi_sck !== p) n++;
      p = spi_sck;
    end
    checks++; if (n != 7) begin failures++; $display("FAIL t5_reach_edge7 got=%0d exp=7", n); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (spi_cs !== 1'b1) begin failures++; $display("FAIL t5_cs got=%b exp=1", spi_cs); end
    checks++; if (spi_sck !== 1'b0) begin failures++; $display("FAIL t5_sck got=%b exp=0", spi_sck); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_busy got=%b exp=0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) step();
    checks++; if (rx_log.size() - s_rx != 0) begin failures++; $display("FAIL t5_no_rx got=%0d exp=0", rx_log.size() - s_rx); end
    snap();
    tx_buf[0] = 8'h5A;
    send_bytes(1, ok);
    checks++; if (!ok || rx_log.size() - s_rx != 1) begin failures++; $display("FAIL t5_next_rx_count got=%0d exp=1", rx_log.size() - s_rx); end
    else begin
      checks++; if (rx_log[s_rx] !== 8'h5A) begin failures++; $display("FAIL t5_next_rx got=%h exp=5a", rx_log[s_rx]); end
    end
  endtask

  task automatic test_late_valid();
    bit ok;
    int n;
    cpol = 1'b0; cpha = 1'b0; div = 2'd1;
    step();
    snap();
    start_byte(8'h11, ok);
    repeat (35) @(posedge clk);
    @(negedge clk);
    checks++; if (spi_cs !== 1'b0) begin failures++; $display("FAIL t6_hold_cs got=%b exp=0", spi_cs); end
    @(posedge clk);
    #1;
    tx_data = 8'h22;
    tx_valid = 1'b1;
    @(negedge clk);
    checks++; if (spi_cs !== 1'b1 || tx_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL t6_deassert got=cs%b/rdy%b/busy%b exp=cs1/rdy0/busy1", spi_cs, tx_ready, busy);
    end
    n = 1;
    for (int i = 0; i < 50 && !tx_ready; i++) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 3) begin failures++; $display("FAIL t6_ready_delay got=%0d exp=3", n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_idle_before_new got=%b exp=0", busy); end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    @(negedge clk);
    checks++; if (spi_cs !== 1'b0 || dut.state_q !== dut.ST_SETUP) begin
      failures++; $display("FAIL t6_new_setup got=cs%b/st%0d exp=cs0/st1", spi_cs, dut.state_q);
    end
    wait_idle(200, ok);
    checks++; if (csrise_tot - s_csr != 2) begin failures++; $display("FAIL t6_cs_rises got=%0d exp=2", csrise_tot - s_csr); end
    checks++; if (rx_log.size() - s_rx != 2) begin failures++; $display("FAIL t6_rx_count got=%0d exp=2", rx_log.size() - s_rx); end
    else begin
      checks++; if (rx_log[s_rx] !== 8'h11 || rx_log[s_rx + 1] !== 8'h22) begin
        failures++; $display("FAIL t6_rx_bytes got=%h,%h exp=11,22", rx_log[s_rx], rx_log[s_rx + 1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_modes();
    test_cfg_change();
    test_reset_mid_frame();
    test_late_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
